// File: rtl/ask4_symbol_source.sv
// Pseudo-random Gray-mapped 4-ASK symbol source with zero-stuff / hold upsampling,
// plus impulse and silent modes for capturing filter responses.
module ask4_symbol_source #(
    parameter logic [21:0]        SEED  = 22'h3FFFFF,
    parameter logic signed [17:0] A_LVL = 18'sd32768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    input  logic [1:0]         mode,
    output logic signed [17:0] x_out,
    output logic [1:0]         sym_idx,
    output logic               sym_valid,
    output logic               align_err
);

    localparam int DATA_W = 18;

    localparam logic [21:0] SEED_EFF = (SEED == 22'd0) ? 22'd1 : SEED;

    localparam logic signed [DATA_W-1:0] LVL_P1 = A_LVL;
    localparam logic signed [DATA_W-1:0] LVL_P3 = DATA_W'(3 * A_LVL);
    localparam logic signed [DATA_W-1:0] LVL_M1 = -LVL_P1;
    localparam logic signed [DATA_W-1:0] LVL_M3 = -LVL_P3;

    localparam logic [1:0] MODE_PN_ZS = 2'b00;
    localparam logic [1:0] MODE_PN_SH = 2'b01;
    localparam logic [1:0] MODE_IMP   = 2'b10;
    localparam logic [1:0] MODE_ZERO  = 2'b11;

    function automatic logic [21:0] lfsr_step(input logic [21:0] q);
        return {q[20:0], q[21] ^ q[20]};
    endfunction

    function automatic logic signed [DATA_W-1:0] gray_level(input logic [1:0] b);
        case (b)
            2'b00:   gray_level = LVL_M3;
            2'b01:   gray_level = LVL_M1;
            2'b11:   gray_level = LVL_P1;
            default: gray_level = LVL_P3;
        endcase
    endfunction

    logic [21:0]              lfsr_p0, lfsr_d;
    logic [1:0]               mode_p0, mode_d;
    logic                     armed_p0, armed_d;
    logic signed [DATA_W-1:0] x_p1, x_d;
    logic [1:0]               idx_p1, idx_d;
    logic                     vld_p1, vld_d;
    logic                     err_p1, err_d;
    logic                     ss, so;
    logic [1:0]               pn_b;

    // Stage p0 -> p1: strobe decode, mode latch, symbol generation
    always_comb begin
        ss       = sym_clk_en & sam_clk_en;
        so       = sam_clk_en & ~sym_clk_en;
        pn_b     = lfsr_p0[21:20];
        x_d      = x_p1;
        idx_d    = idx_p1;
        vld_d    = 1'b0;
        lfsr_d   = (lfsr_p0 == 22'd0) ? 22'd1 : lfsr_p0;
        mode_d   = mode_p0;
        armed_d  = armed_p0;
        err_d    = err_p1 | (sym_clk_en & ~sam_clk_en);

        if (ss) begin
            // The SS that latches a mode also produces that mode's sample.
            mode_d = mode;
            if (mode != MODE_IMP) begin
                armed_d = 1'b1;
            end
            case (mode)
                MODE_PN_ZS, MODE_PN_SH: begin
                    x_d    = gray_level(pn_b);
                    idx_d  = pn_b;
                    vld_d  = 1'b1;
                    lfsr_d = lfsr_step(lfsr_step(lfsr_p0));
                end
                MODE_IMP: begin
                    x_d = '0;
                    if (armed_p0) begin
                        x_d     = LVL_P3;
                        idx_d   = 2'b10;
                        vld_d   = 1'b1;
                        armed_d = 1'b0;
                    end
                end
                default: x_d = '0;
            endcase
        end else if (so) begin
            if (mode_p0 != MODE_PN_SH) begin
                x_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_p0  <= SEED_EFF;
            mode_p0  <= MODE_ZERO;
            armed_p0 <= 1'b1;
            x_p1     <= '0;
            idx_p1   <= 2'b00;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            lfsr_p0  <= lfsr_d;
            mode_p0  <= mode_d;
            armed_p0 <= armed_d;
            x_p1     <= x_d;
            idx_p1   <= idx_d;
            vld_p1   <= vld_d;
            err_p1   <= err_d;
        end
    end

    assign x_out     = x_p1;
    assign sym_idx   = idx_p1;
    assign sym_valid = vld_p1;
    assign align_err = err_p1;

endmodule

// File: tb/tb_ask4_symbol_source.sv
// Scoreboard bench for ask4_symbol_source: directed strobes push expected samples,
// a negedge monitor pops one entry per sample strobe and compares.
module tb_ask4_symbol_source;

    logic               clk = 1'b0;
    logic               reset;
    logic               sam_clk_en;
    logic               sym_clk_en;
    logic [1:0]         mode;
    logic signed [17:0] x_out;
    logic [1:0]         sym_idx;
    logic               sym_valid;
    logic               align_err;

    always #5 clk = ~clk;

    ask4_symbol_source dut (
        .clk        (clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .mode       (mode),
        .x_out      (x_out),
        .sym_idx    (sym_idx),
        .sym_valid  (sym_valid),
        .align_err  (align_err)
    );

    typedef struct {
        logic signed [17:0] x;
        logic [1:0]         idx;
        logic               vld;
        string              tag;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          vld_seen = 0;
    logic        pend     = 1'b0;
    logic [21:0] m_lfsr   = 22'h3FFFFF;

    always @(posedge clk) pend <= sam_clk_en & ~reset;

    // Monitor: every sample strobe yields one registered output sample.
    always @(negedge clk) begin
        exp_t e;
        if (sym_valid === 1'b1) vld_seen++;
        if (pend) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow: output presented with empty scoreboard x=%0d", x_out);
            end else begin
                e = sb.pop_front();
                if (x_out !== e.x || sym_idx !== e.idx || sym_valid !== e.vld) begin
                    failures++;
                    $display("FAIL %s: got x=%0d idx=%b vld=%b, want x=%0d idx=%b vld=%b",
                             e.tag, x_out, sym_idx, sym_valid, e.x, e.idx, e.vld);
                end
            end
        end else if (!reset) begin
            checks++;
            if (sym_valid !== 1'b0) begin
                failures++;
                $display("FAIL valid_idle: got sym_valid=%b, want 0", sym_valid);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic sam, input logic sym, input logic [1:0] m);
        reset      = 1'b0;
        sam_clk_en = sam;
        sym_clk_en = sym;
        mode       = m;
        @(negedge clk);
    endtask

    task automatic strobe(input logic sym, input logic [1:0] m, input logic signed [17:0] ex,
                          input logic [1:0] ei, input logic ev, input string tag);
        exp_t e;
        e.x   = ex;
        e.idx = ei;
        e.vld = ev;
        e.tag = tag;
        sb.push_back(e);
        drive(1'b1, sym, m);
    endtask

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset      = 1'b1;
            sam_clk_en = i[0];
            sym_clk_en = 1'b1;
            mode       = 2'b00;
            @(negedge clk);
        end
        m_lfsr = 22'h3FFFFF;
    endtask

    task automatic pn_next(output logic [1:0] b);
        b = m_lfsr[21:20];
        repeat (2) m_lfsr = {m_lfsr[20:0], m_lfsr[21] ^ m_lfsr[20]};
    endtask

    function automatic logic signed [17:0] level(input logic [1:0] b);
        case (b)
            2'b00:   return -18'sd98304;
            2'b01:   return -18'sd32768;
            2'b11:   return 18'sd32768;
            default: return 18'sd98304;
        endcase
    endfunction

    logic [1:0]         b;
    logic signed [17:0] lv;
    int                 v0;

    initial begin
        reset = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0; mode = 2'b11;
        @(negedge clk);
        apply_reset(4);
        drive(1'b0, 1'b0, 2'b11);
        chk("rst_x", x_out, 0);
        chk("rst_idx", sym_idx, 0);
        chk("rst_vld", sym_valid, 0);
        chk("rst_err", align_err, 0);

        // Silent mode after reset.
        repeat (2) begin
            strobe(1'b1, 2'b11, 18'sd0, 2'b00, 1'b0, "zero_ss");
            repeat (3) strobe(1'b0, 2'b11, 18'sd0, 2'b00, 1'b0, "zero_so");
        end

        // PN zero-stuffed golden run; first 12 symbols hand-derived.
        for (int k = 0; k < 1000; k++) begin
            pn_next(b);
            lv = level(b);
            if (k < 11) begin
                lv = 18'sd32768; b = 2'b11;
            end else if (k == 11) begin
                lv = -18'sd98304; b = 2'b00;
            end
            strobe(1'b1, 2'b00, lv, b, 1'b1, (k < 12) ? "pn_golden_ss" : "pn_ss");
            repeat (3) strobe(1'b0, 2'b00, 18'sd0, b, 1'b0, "pn_so");
        end

        // Mode 00 -> 11 requested mid-symbol; LFSR must freeze.
        pn_next(b);
        strobe(1'b1, 2'b00, level(b), b, 1'b1, "chg_ss");
        strobe(1'b0, 2'b00, 18'sd0, b, 1'b0, "chg_so");
        strobe(1'b0, 2'b11, 18'sd0, b, 1'b0, "chg_so_pending");
        strobe(1'b0, 2'b11, 18'sd0, b, 1'b0, "chg_so_pending");
        repeat (2) begin
            strobe(1'b1, 2'b11, 18'sd0, b, 1'b0, "chg_zero_ss");
            repeat (3) strobe(1'b0, 2'b11, 18'sd0, b, 1'b0, "chg_zero_so");
        end
        pn_next(b);
        strobe(1'b1, 2'b00, level(b), b, 1'b1, "chg_resume_ss");
        repeat (3) strobe(1'b0, 2'b00, 18'sd0, b, 1'b0, "chg_resume_so");

        // Sample-and-hold.
        for (int k = 0; k < 30; k++) begin
            pn_next(b);
            lv = level(b);
            strobe(1'b1, 2'b01, lv, b, 1'b1, "hold_ss");
            repeat (3) strobe(1'b0, 2'b01, lv, b, 1'b0, "hold_so");
        end
        strobe(1'b0, 2'b11, lv, b, 1'b0, "hold_so_pending");
        strobe(1'b1, 2'b11, 18'sd0, b, 1'b0, "hold_to_zero_ss");
        strobe(1'b0, 2'b11, 18'sd0, b, 1'b0, "hold_to_zero_so");

        // Back-to-back symbol strobes.
        for (int k = 0; k < 16; k++) begin
            pn_next(b);
            strobe(1'b1, 2'b00, level(b), b, 1'b1, "b2b_ss");
        end
        strobe(1'b0, 2'b00, 18'sd0, b, 1'b0, "b2b_so");

        // Impulse, silence, impulse again.
        v0 = vld_seen;
        strobe(1'b1, 2'b10, 18'sd98304, 2'b10, 1'b1, "imp1_first");
        strobe(1'b0, 2'b10, 18'sd0, 2'b10, 1'b0, "imp1_so");
        for (int k = 0; k < 63; k++) begin
            strobe(1'b1, 2'b10, 18'sd0, 2'b10, 1'b0, "imp1_later_ss");
            strobe(1'b0, 2'b10, 18'sd0, 2'b10, 1'b0, "imp1_so");
        end
        repeat (4) strobe(1'b1, 2'b11, 18'sd0, 2'b10, 1'b0, "imp_gap_ss");
        strobe(1'b1, 2'b10, 18'sd98304, 2'b10, 1'b1, "imp2_first");
        repeat (10) strobe(1'b1, 2'b10, 18'sd0, 2'b10, 1'b0, "imp2_later_ss");
        drive(1'b0, 1'b0, 2'b10);
        chk("imp_vld_count", vld_seen - v0, 2);

        // Misaligned enable: sticky flag, no data change, no LFSR advance.
        pn_next(b);
        lv = level(b);
        strobe(1'b1, 2'b01, lv, b, 1'b1, "mis_pre_ss");
        strobe(1'b0, 2'b01, lv, b, 1'b0, "mis_pre_so");
        drive(1'b0, 1'b1, 2'b01);
        chk("mis_err_set", align_err, 1);
        chk("mis_x_hold", x_out, lv);
        strobe(1'b0, 2'b01, lv, b, 1'b0, "mis_post_so");
        drive(1'b0, 1'b0, 2'b01);
        chk("mis_err_sticky", align_err, 1);
        pn_next(b);
        lv = level(b);
        strobe(1'b1, 2'b01, lv, b, 1'b1, "mis_next_ss");
        strobe(1'b0, 2'b01, lv, b, 1'b0, "mis_next_so");

        // Reset mid-symbol, enables active during reset.
        apply_reset(3);
        drive(1'b0, 1'b0, 2'b00);
        chk("midrst_err", align_err, 0);
        chk("midrst_x", x_out, 0);
        chk("midrst_idx", sym_idx, 0);
        pn_next(b);
        strobe(1'b1, 2'b00, 18'sd32768, 2'b11, 1'b1, "restart_sym0");
        strobe(1'b0, 2'b00, 18'sd0, 2'b11, 1'b0, "restart_so");
        strobe(1'b1, 2'b00, 18'sd32768, 2'b11, 1'b1, "restart_sym1");

        drive(1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 2'b00);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ask4_symbol_source.md
# ask4_symbol_source

Pseudo-random 4-ASK symbol source and upsampler that drives the 18-bit signed `x_in` of the pulse-shaping / halfband filter chain. It generates Gray-mapped 4-level symbols from a 22-bit LFSR on every symbol strobe. Between symbols it zero-stuffs or holds at the sample rate. It also offers impulse and silent modes so filter impulse responses can be captured without file-driven stimulus.

## Interface
- `SEED`, default 22'h3FFFFF: LFSR reset state. A value of 0 is replaced by 22'h000001.
- `A_LVL`, default 18'sd32768: inner level A in 1s17 format. Outer level is 3·A. Legal range is 1..43690.
- `clk` input, 1 bit: system clock, the same clock as the filter. All logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `sam_clk_en` input, 1 bit: sample-rate enable. One-cycle pulse.
- `sym_clk_en` input, 1 bit: symbol-rate enable. Must coincide with a `sam_clk_en` pulse.
- `mode` input, 2 bits: 00 = PN zero-stuffed, 01 = PN sample-and-hold, 10 = impulse, 11 = zero.
- `x_out` output, 18 bits signed 1s17: sample to the filter `x_in`.
- `sym_idx` output, 2 bits: Gray bits of the current symbol.
- `sym_valid` output, 1 bit: one-cycle pulse when `x_out` loads a new symbol.
- `align_err` output, 1 bit: sticky flag for `sym_clk_en` asserted without `sam_clk_en`.

## Operation
- Strobe definitions:
  - Symbol strobe (SS) = `sym_clk_en & sam_clk_en`.
  - Sample-only strobe (SO) = `sam_clk_en & ~sym_clk_en`.
  - `sym_clk_en & ~sam_clk_en` is ignored for data and sets `align_err` until reset.
- LFSR: 22-bit Fibonacci.
  - Per shift: fb = q[21]^q[20], q ← {q[20:0], fb}.
  - On each SS in modes 00/01, the symbol bits b = q[21:20] are taken from the pre-shift state, then the LFSR shifts twice in the same cycle.
  - The LFSR freezes in modes 10/11 and between SS.
  - If the state is ever all-zero, it loads 22'h000001 on the next cycle.
- Gray map from b to level: 00 → −3A, 01 → −A, 11 → +A, 10 → +3A. Constants are computed at elaboration; no runtime multiply. No saturation is needed within the legal `A_LVL` range.
- Mode register `mode_q`:
  - Samples `mode` only on SS. A mode change takes effect at the next symbol boundary, never mid-symbol.
  - Reset value is 11.
  - The SS that latches a new mode also produces that mode's output.
- Per-mode output (applied on SS using the new `mode_q`, and on SO):
  - 00: SS → x_out = level(b), sym_valid = 1. SO → x_out = 0.
  - 01: SS → same as 00. SO → x_out holds.
  - 10: the first SS after entering mode 10 gives x_out = +3A, sym_idx = 10, sym_valid = 1. Every later SS and SO gives 0. The impulse re-arms only when the mode leaves 10 and re-enters.
  - 11: x_out = 0, sym_valid = 0, LFSR frozen.
- `sym_idx` updates only together with `sym_valid`. Otherwise it holds.
- Outside `sam_clk_en`, all outputs hold, except that `sym_valid` returns to 0.

## Timing
- Every output is registered. `x_out`, `sym_idx` and `sym_valid` change on the edge that samples the strobe, so they are visible the cycle after the enable is high. Latency is 1 clk.
- `sym_valid` is high for exactly one clk per SS that carries a symbol.
- Reset values: x_out = 0, sym_idx = 00, sym_valid = 0, align_err = 0, LFSR = SEED (or 1 if SEED is 0), mode_q = 11, impulse armed.
- Reset behaviour:
  - Reset wins over every enable in the same cycle.
  - Reset asserted mid-symbol discards the held value and restarts the LFSR at SEED.
  - After reset releases, the first SS starts the sequence from symbol 0.
- Back-to-back SS on consecutive clks (sym rate = sam rate = clk) is legal. Each SS yields one symbol and 2 LFSR shifts.

## Test plan
- Reset check: assert `reset` with the enables toggling. Required: x_out = 0, sym_valid = 0, sym_idx = 00, align_err = 0. After reset releases with mode = 11, outputs stay 0.
- PN golden sequence: mode 00, SEED default, A = 32768, SS every 4th SO. Required:
  - Symbols 0–10 give x_out = +32768 (sym_idx = 11).
  - Symbol 11 gives −98304 (sym_idx = 00).
  - Each of the 3 following SO gives x_out = 0.
  - The full sequence matches a Python model for 1000 symbols.
- Hold mode: mode 01, same stimulus. Required: x_out holds the symbol value on every SO, and changes only on SS, one clk after the strobe.
- Impulse: mode 10 for 64 SS, then 11, then 10 again. Required: exactly one +98304 sample after each entry into mode 10, with zeros elsewhere, and sym_valid pulses exactly twice in total.
- Mode change timing: switch mode 00 → 11 mid-symbol. Required: the current held/zero behaviour continues until the next SS, which outputs 0. The LFSR does not advance; after returning to 00, the sequence resumes at the next unused symbol.
- Misaligned enable and mid-run reset: pulse `sym_clk_en` alone once. Required: align_err = 1 and stays 1, with no data change. Then assert reset mid-symbol. Required: align_err clears and the sequence restarts at symbol 0 (+32768).
